conv_bank_memory: RTL and testbench

Multi-channel, simple-dual-port signed storage for the convolution datapath, replacing the single-channel single-port memory. It holds NUM_CH parallel channels of DEPTH x WIDTH words and accepts one write and one read per cycle. Reads return registered data with a valid strobe, and per-channel write masks are supported. A hardware clear sequencer zeroes the whole array between frames.

---
 rtl/conv_mem_pkg.sv | 34 +++
 rtl/conv_mem_bank.sv | 43 ++++
 rtl/conv_bank_memory.sv | 150 +++++++++++++++
 tb/tb_conv_bank_memory.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Shared types and helpers for the multi-channel convolution bank memory.
// Holds the clear-sequencer state type and channel slice pack/unpack helpers.
// Helpers work on a wide bus so any NUM_CH*WIDTH up to BUS_MAX_W fits.
package conv_mem_pkg;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    localparam int unsigned BUS_MAX_W  = 1024;
    localparam int unsigned WORD_MAX_W = 64;

    // Extract channel ch (w bits wide) from a packed channel bus.
    function automatic logic [WORD_MAX_W-1:0] unpack_ch(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          ch,
        input int unsigned          w
    );
        logic [WORD_MAX_W-1:0] mask;
        mask      = (WORD_MAX_W'(1) << w) - WORD_MAX_W'(1);
        unpack_ch = WORD_MAX_W'(bus >> (ch * w)) & mask;
    endfunction

    // Replace channel ch (w bits wide) of a packed channel bus with word.
    function automatic logic [BUS_MAX_W-1:0] pack_ch(
        input logic [BUS_MAX_W-1:0]  bus,
        input int unsigned           ch,
        input int unsigned           w,
        input logic [WORD_MAX_W-1:0] word
    );
        logic [BUS_MAX_W-1:0] mask;
        mask    = ((BUS_MAX_W'(1) << w) - BUS_MAX_W'(1)) << (ch * w);
        pack_ch = (bus & ~mask) | ((BUS_MAX_W'(word) << (ch * w)) & mask);
    endfunction

endpackage

// File: rtl/conv_mem_bank.sv
// One channel of DEPTH x WIDTH signed storage with a masked write port and registered read.
// Latency: read data registered, valid one edge after rd_en; writes visible to the next read.
// Backpressure: none; the parent gates wr_en/rd_en and supplies an alternate read word.
module conv_mem_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_use_alt,
    input  logic [WIDTH-1:0] rd_alt_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage array: no reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read register: loads the old array word (read-before-write) or the parent's
    // alternate word (bypass / out-of-range zero), holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= rd_use_alt ? rd_alt_data : r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/conv_bank_memory.sv
// NUM_CH-channel simple-dual-port signed memory with masked writes and a hardware clear sweep.
// Latency: reads 1 cycle (rd_valid strobe); clear sweep takes DEPTH cycles then pulses clr_done.
// Backpressure: none; accesses during the sweep are dropped and flagged in sticky access_err.
// Optional: define CONV_MEM_BYPASS_EN to forward same-cycle same-address write data to the read.
module conv_bank_memory
    import conv_mem_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 64,
    parameter  int NUM_CH = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [NUM_CH-1:0]       wr_mask,
    input  logic [NUM_CH*WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [NUM_CH*WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    clr_req,
    output logic                    busy,
    output logic                    clr_done,
    output logic                    access_err
);

    clr_state_t    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_clr_done;
    logic          r_access_err;
    logic          r_rd_valid;

    logic          w_idle;
    logic          w_clearing;
    logic          w_wr_in_range;
    logic          w_rd_oob;
    logic          w_wr_ok;
    logic          w_rd_acc;
    logic [AW-1:0] w_bank_waddr;

    // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
    assign w_wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
    assign w_rd_oob      = ({1'b0, rd_addr} >= (AW+1)'(DEPTH));

    assign w_idle       = (r_state == IDLE);
    assign w_clearing   = (r_state == CLEAR);
    assign w_wr_ok      = w_idle & wr_en & w_wr_in_range;
    assign w_rd_acc     = w_idle & rd_en;
    assign w_bank_waddr = w_clearing ? r_cnt : wr_addr;

    // Clear sequencer: sweeps every address once, owns busy/clr_done/access_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_clr_done   <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state      <= CLEAR;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_access_err <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (wr_en || rd_en) begin
                        r_access_err <= 1'b1;
                    end
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read strobe: one cycle per read accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [WIDTH-1:0] w_wr_slice;
            logic [WIDTH-1:0] w_wdata;
            logic             w_we;
            logic             w_use_alt;
            logic [WIDTH-1:0] w_alt;

            assign w_wr_slice = WIDTH'(unpack_ch(BUS_MAX_W'(wr_data), c, WIDTH));
            assign w_we       = w_clearing | (w_wr_ok & wr_mask[c]);
            assign w_wdata    = w_clearing ? '0 : w_wr_slice;

`ifdef CONV_MEM_BYPASS_EN
            // Forward the incoming word when this channel is written at the read address.
            assign w_use_alt = w_rd_oob | (w_wr_ok & wr_mask[c] & (wr_addr == rd_addr));
            assign w_alt     = w_rd_oob ? '0 : w_wr_slice;
`else
            // Array read is naturally read-before-write; only out-of-range reads are replaced.
            assign w_use_alt = w_rd_oob;
            assign w_alt     = '0;
`endif

            conv_mem_bank #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_bank (
                .clk         (clk),
                .rst_n       (rst_n),
                .wr_en       (w_we),
                .wr_addr     (w_bank_waddr),
                .wr_data     (w_wdata),
                .rd_en       (w_rd_acc),
                .rd_addr     (rd_addr),
                .rd_use_alt  (w_use_alt),
                .rd_alt_data (w_alt),
                .rd_data     (rd_data[c*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign rd_valid   = r_rd_valid;
    assign busy       = r_busy;
    assign clr_done   = r_clr_done;
    assign access_err = r_access_err;

endmodule

// File: tb/tb_conv_bank_memory.sv
// Self-checking bench for conv_bank_memory against a behavioural per-address model.
// Latency: model predicts outputs one edge after each driven input set.
// Backpressure: model tracks the clear sweep as a remaining-cycle count.
module tb_conv_bank_memory;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 64;
    localparam int NUM_CH = 4;
    localparam int AW     = 6;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    wr_en = 1'b0;
    logic [AW-1:0]           wr_addr = '0;
    logic [NUM_CH-1:0]       wr_mask = '0;
    logic [NUM_CH*WIDTH-1:0] wr_data = '0;
    logic                    rd_en = 1'b0;
    logic [AW-1:0]           rd_addr = '0;
    logic [NUM_CH*WIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic                    clr_req = 1'b0;
    logic                    busy;
    logic                    clr_done;
    logic                    access_err;

    always #5 clk = ~clk;

    conv_bank_memory #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .clr_req    (clr_req),
        .busy       (busy),
        .clr_done   (clr_done),
        .access_err (access_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: memory contents, last read word, flags, remaining sweep cycles.
    logic [WIDTH-1:0] m_mem [DEPTH][NUM_CH];
    logic [WIDTH-1:0] m_rd  [NUM_CH];
    logic             m_valid = 1'b0;
    logic             m_done  = 1'b0;
    logic             m_err   = 1'b0;
    int               m_left  = 0;
    int               m_pos   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] w4(input logic [15:0] c0, input logic [15:0] c1,
                                       input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [63:0] m_rd_bus();
        return {m_rd[3], m_rd[2], m_rd[1], m_rd[0]};
    endfunction

    // Drive one cycle of inputs, advance the model, compare every output.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [3:0] wm,
                       input logic [63:0] wd, input logic re, input logic [AW-1:0] ra,
                       input logic cr);
        wr_en = we; wr_addr = wa; wr_mask = wm; wr_data = wd;
        rd_en = re; rd_addr = ra; clr_req = cr;
        @(posedge clk); #1;
        m_done = 1'b0;
        if (m_left == 0) begin
            m_valid = re;
            if (re) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    logic byp;
                    byp = 1'b0;
`ifdef CONV_MEM_BYPASS_EN
                    byp = we && wm[c] && (wa == ra);
`endif
                    m_rd[c] = byp ? wd[c*WIDTH +: WIDTH] : m_mem[ra][c];
                end
            end
            if (we) begin
                for (int c = 0; c < NUM_CH; c++)
                    if (wm[c]) m_mem[wa][c] = wd[c*WIDTH +: WIDTH];
            end
            if (cr) begin
                m_left = DEPTH;
                m_pos  = 0;
                m_err  = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            if (we || re) m_err = 1'b1;
            for (int c = 0; c < NUM_CH; c++) m_mem[m_pos][c] = '0;
            m_pos++;
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end
        chk("busy",       64'(busy),       64'(m_left > 0));
        chk("clr_done",   64'(clr_done),   64'(m_done));
        chk("access_err", 64'(access_err), 64'(m_err));
        chk("rd_valid",   64'(rd_valid),   64'(m_valid));
        chk("rd_data",    rd_data,         m_rd_bus());
    endtask

    task automatic idle();
        cyc(1'b0, '0, 4'h0, 64'h0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [3:0] m, input logic [63:0] d);
        cyc(1'b1, a, m, d, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1'b0, '0, 4'h0, 64'h0, 1'b1, a, 1'b0);
    endtask

    int n_busy;
    int n_done;
    int seen;

    initial begin
        for (int a = 0; a < DEPTH; a++)
            for (int c = 0; c < NUM_CH; c++) m_mem[a][c] = '0;
        for (int c = 0; c < NUM_CH; c++) m_rd[c] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data",    rd_data,         64'h0);
        chk("rst_rd_valid",   64'(rd_valid),   64'h0);
        chk("rst_busy",       64'(busy),       64'h0);
        chk("rst_clr_done",   64'(clr_done),   64'h0);
        chk("rst_access_err", 64'(access_err), 64'h0);
        rst_n = 1'b1;

        // Bring the array to a known all-zero state.
        cyc(1'b0, '0, 4'h0, 64'h0, 1'b0, '0, 1'b1);
        repeat (DEPTH) idle();

        // Full-mask write then read
        wr(6'd5, 4'hF, w4(16'h1234, 16'hFFFF, 16'h8000, 16'h0001));
        rd(6'd5);
        chk("t1_valid", 64'(rd_valid), 64'h1);
        chk("t1_data",  rd_data, w4(16'h1234, 16'hFFFF, 16'h8000, 16'h0001));

        // Masked write
        wr(6'd9, 4'hF, w4(16'h1111, 16'h1111, 16'h1111, 16'h1111));
        wr(6'd9, 4'b0101, w4(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA));
        rd(6'd9);
        chk("t2_data", rd_data, w4(16'hAAAA, 16'h1111, 16'hAAAA, 16'h1111));
        idle();
        chk("t2_hold", rd_data, w4(16'hAAAA, 16'h1111, 16'hAAAA, 16'h1111));

        // Same-cycle write and read to one address
        wr(6'd3, 4'hF, w4(16'h0003, 16'h0003, 16'h0003, 16'h0003));
        cyc(1'b1, 6'd3, 4'hF, w4(16'h7777, 16'h7777, 16'h7777, 16'h7777), 1'b1, 6'd3, 1'b0);
`ifdef CONV_MEM_BYPASS_EN
        chk("t3_bypass", rd_data, w4(16'h7777, 16'h7777, 16'h7777, 16'h7777));
`else
        chk("t3_rbw", rd_data, w4(16'h0003, 16'h0003, 16'h0003, 16'h0003));
`endif
        rd(6'd3);
        chk("t3_after", rd_data, w4(16'h7777, 16'h7777, 16'h7777, 16'h7777));

        // Fill, sweep with a mid-sweep write, verify all zero
        for (int a = 0; a < DEPTH; a++)
            wr(6'(a), 4'hF, {$urandom, $urandom} | 64'h0001_0001_0001_0001);
        cyc(1'b0, '0, 4'h0, 64'h0, 1'b0, '0, 1'b1);
        n_busy = busy ? 1 : 0;
        n_done = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 5) wr(6'd10, 4'hF, w4(16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A));
            else idle();
            if (busy) n_busy++;
            if (clr_done) n_done++;
        end
        chk("t4_busy_cycles", 64'(n_busy), 64'd64);
        chk("t4_done_pulses", 64'(n_done), 64'd1);
        chk("t4_access_err",  64'(access_err), 64'h1);
        for (int a = 0; a < DEPTH; a++) begin
            rd(6'(a));
            chk("t4_zero", rd_data, 64'h0);
        end

        // Reset during the sweep
        for (int a = 0; a < DEPTH; a++)
            wr(6'(a), 4'hF, w4(16'(a + 1), 16'hC0DE, 16'(a + 100), 16'hBEEF));
        cyc(1'b0, '0, 4'h0, 64'h0, 1'b0, '0, 1'b1);
        repeat (19) idle();
        cyc(1'b1, 6'd50, 4'hF, 64'h0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        #1;
        m_left = 0; m_err = 1'b0; m_done = 1'b0; m_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_rd[c] = '0;
        chk("t5_busy",       64'(busy),       64'h0);
        chk("t5_clr_done",   64'(clr_done),   64'h0);
        chk("t5_rd_valid",   64'(rd_valid),   64'h0);
        chk("t5_access_err", 64'(access_err), 64'h0);
        chk("t5_rd_data",    rd_data,         64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 20; a++) begin
            rd(6'(a));
            chk("t5_cleared", rd_data, 64'h0);
        end
        rd(6'd20);
        chk("t5_addr20", rd_data, w4(16'd21, 16'hC0DE, 16'd120, 16'hBEEF));
        rd(6'd40);
        chk("t5_addr40", rd_data, w4(16'd41, 16'hC0DE, 16'd140, 16'hBEEF));

        // clr_req together with a write
        cyc(1'b1, 6'd2, 4'hF, w4(16'h5555, 16'h5555, 16'h5555, 16'h5555), 1'b0, '0, 1'b1);
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            idle();
            if (clr_done) seen = 1;
        end
        chk("t6_done_seen", 64'(seen), 64'h1);
        rd(6'd2);
        chk("t6_addr2", rd_data, 64'h0);

        // Randomised traffic with occasional sweeps
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom), 6'($urandom), 4'($urandom), {$urandom, $urandom},
                1'($urandom), 6'($urandom), ($urandom_range(0, 199) == 0));
        end
        // Collision focus: reads and writes on a small address window
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom), 6'($urandom_range(0, 3)), 4'($urandom), {$urandom, $urandom},
                1'($urandom), 6'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
